isp_ae_ctrl: RTL and testbench

//  Closed-loop auto-exposure controller driven by the per-frame AE statistics block.
//  On each frame-done pulse it:
//   - computes the frame mean (sum/cnt) with a sequential divider;
//   - compares the mean against a target band;
//   - steps a sensor exposure register proportionally.
//  It sits between the ISP stats and the sensor-config path (the I2C/SCCB writer consumes out_exposure).

---
 rtl/isp_ae_ctrl_if.sv | 48 ++++
 rtl/isp_ae_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_isp_ae_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/isp_ae_ctrl_if.sv
// ---------------------------------------------------------------------------
// isp_ae_ctrl_if
//   Bundles the statistics input, the control knobs and the exposure/mean
//   outputs of the auto-exposure controller.
//   master : drives the control knobs and the stats strobe (ISP side / bench).
//   slave  : the controller itself.
//
//   Handshake: stat_done is a valid-only strobe with no ready. stat_cnt and
//   stat_sum are valid only in the cycle stat_done is high. A strobe that
//   arrives while the controller is busy is dropped. out_exp_valid and
//   out_mean_valid are likewise one-cycle valid-only strobes; their data
//   (out_exposure, out_mean) holds until the next strobe.
//   dbg_state exposes the controller FSM state for observation.
// ---------------------------------------------------------------------------
interface isp_ae_ctrl_if #(
    parameter int BITS     = 8,
    parameter int OUT_BITS = 32,
    parameter int EXP_BITS = 16
);
    logic                enable;
    logic [BITS-1:0]     target;
    logic [BITS-1:0]     tolerance;
    logic [3:0]          skip_frames;
    logic                stat_done;
    logic [OUT_BITS-1:0] stat_cnt;
    logic [OUT_BITS-1:0] stat_sum;
    logic [EXP_BITS-1:0] out_exposure;
    logic                out_exp_valid;
    logic [BITS-1:0]     out_mean;
    logic                out_mean_valid;
    logic                out_locked;
    logic                out_busy;
    logic [1:0]          dbg_state;

    modport master (
        output enable, target, tolerance, skip_frames,
        output stat_done, stat_cnt, stat_sum,
        input  out_exposure, out_exp_valid, out_mean, out_mean_valid,
        input  out_locked, out_busy, dbg_state
    );

    modport slave (
        input  enable, target, tolerance, skip_frames,
        input  stat_done, stat_cnt, stat_sum,
        output out_exposure, out_exp_valid, out_mean, out_mean_valid,
        output out_locked, out_busy, dbg_state
    );
endinterface

// File: rtl/isp_ae_ctrl.sv
// ---------------------------------------------------------------------------
// isp_ae_ctrl
//   Closed-loop auto-exposure controller. On each accepted frame-done strobe
//   it divides stat_sum by stat_cnt (restoring divider, one bit per cycle),
//   compares the mean against target +/- tolerance and steps the exposure
//   register by exposure >> STEP_SHIFT (at least 1), clamped to
//   [EXP_MIN, EXP_MAX].
// Ports
//   pclk   : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : isp_ae_ctrl_if.slave (controls, stats strobe, results, dbg_state)
// ---------------------------------------------------------------------------
module isp_ae_ctrl #(
    parameter int BITS       = 8,
    parameter int OUT_BITS   = 32,
    parameter int EXP_BITS   = 16,
    parameter int EXP_MIN    = 1,
    parameter int EXP_MAX    = 1000,
    parameter int EXP_INIT   = 500,
    parameter int STEP_SHIFT = 3
) (
    input  logic          pclk,
    input  logic          rst_n,
    isp_ae_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_CMP  = 2'd2,
        ST_UPD  = 2'd3
    } state_t;

    localparam int CW = $clog2(OUT_BITS + 1);
    localparam logic [EXP_BITS:0]   EXP_MIN_X  = (EXP_BITS + 1)'(EXP_MIN);
    localparam logic [EXP_BITS:0]   EXP_MAX_X  = (EXP_BITS + 1)'(EXP_MAX);
    localparam logic [EXP_BITS-1:0] EXP_INIT_V = EXP_BITS'(EXP_INIT);
    localparam logic [OUT_BITS-1:0] MEAN_MAX_W = {{(OUT_BITS-BITS){1'b0}}, {BITS{1'b1}}};

    state_t              state_q, state_d;
    logic [CW-1:0]       div_cnt_q, div_cnt_d;
    logic [OUT_BITS-1:0] divisor_q, divisor_d;
    logic [OUT_BITS-1:0] rem_q, rem_d;
    logic [OUT_BITS-1:0] quo_q, quo_d;
    logic [BITS-1:0]     mean_q, mean_d;
    logic                mean_valid_q, mean_valid_d;
    logic [EXP_BITS-1:0] exp_q, exp_d;
    logic                exp_valid_q, exp_valid_d;
    logic                locked_q, locked_d;
    logic [3:0]          skip_q, skip_d;

    // Datapath helpers
    logic [OUT_BITS:0]   rem_shift;
    logic [OUT_BITS:0]   rem_sub;
    logic [BITS-1:0]     mean_sat;
    logic [BITS-1:0]     band_lo;
    logic [BITS:0]       hi_sum;
    logic [BITS-1:0]     band_hi;
    logic                in_band;
    logic [EXP_BITS-1:0] step_raw;
    logic [EXP_BITS:0]   step_x;
    logic [EXP_BITS:0]   exp_x;
    logic [EXP_BITS:0]   exp_up;
    logic [EXP_BITS:0]   exp_up_c;
    logic [EXP_BITS:0]   exp_dn_c;
    logic [EXP_BITS:0]   exp_new;

    always_comb begin
        // Restoring divider step: the dividend is held in quo_q and shifted
        // out of its MSB while quotient bits shift in at the LSB.
        rem_shift = {rem_q, quo_q[OUT_BITS-1]};
        rem_sub   = rem_shift - {1'b0, divisor_q};
        // rem_sub[OUT_BITS] is the borrow: set when rem_shift < divisor.

        mean_sat = (quo_q > MEAN_MAX_W) ? {BITS{1'b1}} : quo_q[BITS-1:0];

        band_lo = (bus.target >= bus.tolerance) ? (bus.target - bus.tolerance) : '0;
        hi_sum  = {1'b0, bus.target} + {1'b0, bus.tolerance};
        band_hi = hi_sum[BITS] ? {BITS{1'b1}} : hi_sum[BITS-1:0];
        in_band = (mean_q >= band_lo) && (mean_q <= band_hi);

        step_raw = exp_q >> STEP_SHIFT;
        step_x   = (step_raw == '0) ? (EXP_BITS + 1)'(1) : {1'b0, step_raw};
        exp_x    = {1'b0, exp_q};
        exp_up   = exp_x + step_x;
        exp_up_c = (exp_up > EXP_MAX_X) ? EXP_MAX_X : exp_up;
        exp_dn_c = (exp_x < step_x + EXP_MIN_X) ? EXP_MIN_X : (exp_x - step_x);

        if (mean_q < band_lo) begin
            exp_new = exp_up_c;
        end else if (mean_q > band_hi) begin
            exp_new = exp_dn_c;
        end else begin
            exp_new = exp_x;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        divisor_d    = divisor_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        mean_d       = mean_q;
        mean_valid_d = 1'b0;
        exp_d        = exp_q;
        exp_valid_d  = 1'b0;
        locked_d     = locked_q;
        skip_d       = skip_q;

        if (!bus.enable) begin
            // Abort: nothing partially computed is ever written out.
            state_d  = ST_IDLE;
            skip_d   = 4'd0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.stat_done) begin
                        if (skip_q != 4'd0) begin
                            skip_d = skip_q - 4'd1;
                        end else if (bus.stat_cnt != '0) begin
                            divisor_d = bus.stat_cnt;
                            quo_d     = bus.stat_sum;
                            rem_d     = '0;
                            div_cnt_d = '0;
                            state_d   = ST_DIV;
                        end
                    end
                end
                ST_DIV: begin
                    if (!rem_sub[OUT_BITS]) begin
                        rem_d = rem_sub[OUT_BITS-1:0];
                        quo_d = {quo_q[OUT_BITS-2:0], 1'b1};
                    end else begin
                        rem_d = rem_shift[OUT_BITS-1:0];
                        quo_d = {quo_q[OUT_BITS-2:0], 1'b0};
                    end
                    div_cnt_d = div_cnt_q + CW'(1);
                    if (div_cnt_q == CW'(OUT_BITS - 1)) begin
                        state_d = ST_CMP;
                    end
                end
                ST_CMP: begin
                    mean_d       = mean_sat;
                    mean_valid_d = 1'b1;
                    state_d      = ST_UPD;
                end
                ST_UPD: begin
                    locked_d = in_band;
                    if (exp_new != exp_x) begin
                        exp_d       = exp_new[EXP_BITS-1:0];
                        exp_valid_d = 1'b1;
                        skip_d      = bus.skip_frames;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= '0;
            divisor_q    <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            mean_q       <= '0;
            mean_valid_q <= 1'b0;
            exp_q        <= EXP_INIT_V;
            exp_valid_q  <= 1'b0;
            locked_q     <= 1'b0;
            skip_q       <= 4'd0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            divisor_q    <= divisor_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            mean_q       <= mean_d;
            mean_valid_q <= mean_valid_d;
            exp_q        <= exp_d;
            exp_valid_q  <= exp_valid_d;
            locked_q     <= locked_d;
            skip_q       <= skip_d;
        end
    end

    assign bus.out_exposure   = exp_q;
    assign bus.out_exp_valid  = exp_valid_q;
    assign bus.out_mean       = mean_q;
    assign bus.out_mean_valid = mean_valid_q;
    assign bus.out_locked     = locked_q;
    assign bus.out_busy       = (state_q != ST_IDLE);
    assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_isp_ae_ctrl.sv
module tb_isp_ae_ctrl;
    localparam int BITS     = 8;
    localparam int OUT_BITS = 32;
    localparam int EXP_BITS = 16;
    localparam int EXP_MIN  = 1;
    localparam int EXP_MAX  = 1000;
    localparam int EXP_INIT = 500;

    // ---------------- clock / reset ----------------
    logic pclk = 1'b0;
    logic rst_n = 1'b1;
    always #5 pclk = ~pclk;

    isp_ae_ctrl_if #(.BITS(BITS), .OUT_BITS(OUT_BITS), .EXP_BITS(EXP_BITS)) bus ();

    isp_ae_ctrl #(
        .BITS(BITS), .OUT_BITS(OUT_BITS), .EXP_BITS(EXP_BITS),
        .EXP_MIN(EXP_MIN), .EXP_MAX(EXP_MAX), .EXP_INIT(EXP_INIT), .STEP_SHIFT(3)
    ) dut (
        .pclk(pclk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame-level view: an accepted frame keeps the block busy for
    // OUT_BITS+2 edges; the mean appears one edge before the end, the
    // exposure decision on the last edge.
    logic [EXP_BITS-1:0] exp_q[$];
    int     m_exp, m_skip, m_mean, m_busy;
    bit     m_locked, m_mv, m_ev;
    longint p_sum, p_cnt, q;
    int     lo, hi, step, nxt;

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_exp = EXP_INIT; m_skip = 0; m_mean = 0; m_busy = 0;
            m_locked = 0; m_mv = 0; m_ev = 0;
            exp_q.delete();
        end else begin
            m_mv = 0;
            m_ev = 0;
            if (!bus.enable) begin
                m_busy = 0; m_skip = 0; m_locked = 0;
            end else if (m_busy == 0) begin
                if (bus.stat_done) begin
                    if (m_skip != 0) m_skip--;
                    else if (bus.stat_cnt != 0) begin
                        p_sum  = longint'({32'd0, bus.stat_sum});
                        p_cnt  = longint'({32'd0, bus.stat_cnt});
                        m_busy = OUT_BITS + 2;
                    end
                end
            end else begin
                m_busy--;
                if (m_busy == 1) begin
                    q      = p_sum / p_cnt;
                    m_mean = (q > 255) ? 255 : int'(q);
                    m_mv   = 1;
                end else if (m_busy == 0) begin
                    lo = int'(bus.target) - int'(bus.tolerance);
                    if (lo < 0) lo = 0;
                    hi = int'(bus.target) + int'(bus.tolerance);
                    if (hi > 255) hi = 255;
                    step = m_exp / 8;
                    if (step < 1) step = 1;
                    if (m_mean < lo) nxt = (m_exp + step > EXP_MAX) ? EXP_MAX : m_exp + step;
                    else if (m_mean > hi) nxt = (m_exp - step < EXP_MIN) ? EXP_MIN : m_exp - step;
                    else nxt = m_exp;
                    m_locked = (m_mean >= lo) && (m_mean <= hi);
                    if (nxt != m_exp) begin
                        m_exp  = nxt;
                        m_ev   = 1;
                        m_skip = int'(bus.skip_frames);
                        exp_q.push_back(EXP_BITS'(m_exp));
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge pclk) begin
        if (rst_n === 1'b1) begin
            chk("out_exposure",   longint'(bus.out_exposure),   m_exp);
            chk("out_exp_valid",  longint'(bus.out_exp_valid),  m_ev);
            chk("out_mean",       longint'(bus.out_mean),       m_mean);
            chk("out_mean_valid", longint'(bus.out_mean_valid), m_mv);
            chk("out_locked",     longint'(bus.out_locked),     m_locked);
            chk("out_busy",       longint'(bus.out_busy),       (m_busy != 0));
            if (bus.out_exp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_exp_pulse", 1, 0);
                end else begin
                    chk("sb_exposure", longint'(bus.out_exposure), longint'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drives one frame and reports, relative to the sampling edge k, the
    // edge after which out_mean_valid / out_exp_valid pulsed (-1 = never).
    task automatic frame(input logic [31:0] cnt, input logic [31:0] sum,
                         output int mlat, output int elat);
        bit done = 0;
        @(negedge pclk);
        bus.stat_done = 1'b1; bus.stat_cnt = cnt; bus.stat_sum = sum;
        @(posedge pclk); #1;
        bus.stat_done = 1'b0;
        mlat = -1; elat = -1;
        for (int j = 1; j <= 80; j++) begin
            @(posedge pclk); #1;
            if (bus.out_mean_valid === 1'b1 && mlat < 0) mlat = j;
            if (bus.out_exp_valid === 1'b1 && elat < 0) elat = j;
            if (bus.out_busy !== 1'b1) begin done = 1; break; end
        end
        if (!done) chk("frame_timeout", 1, 0);
    endtask

    // Starts a frame and drops enable after 'at' edges.
    task automatic abort_frame(input logic [31:0] cnt, input logic [31:0] sum, input int at);
        @(negedge pclk);
        bus.stat_done = 1'b1; bus.stat_cnt = cnt; bus.stat_sum = sum;
        @(posedge pclk); #1;
        bus.stat_done = 1'b0;
        repeat (at) @(posedge pclk);
        #1 bus.enable = 1'b0;
        @(posedge pclk); #1;
        bus.enable = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    int ml, el, pulses, r;
    int ladder[5] = '{632, 711, 799, 898, 1000};
    logic [31:0] rc, rs;

    initial begin
        bus.enable = 1'b1; bus.target = 8'd128; bus.tolerance = 8'd8;
        bus.skip_frames = 4'd0; bus.stat_done = 1'b0;
        bus.stat_cnt = '0; bus.stat_sum = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_exposure", longint'(bus.out_exposure), 500);
        chk("reset_busy", longint'(bus.out_busy), 0);
        idle(3);
        @(negedge pclk) rst_n = 1'b1;

        // 1: long idle
        idle(100);
        chk("idle_exposure", longint'(bus.out_exposure), 500);
        chk("idle_locked", longint'(bus.out_locked), 0);

        // 2: dark frame, latency
        frame(32'd1000, 32'd50000, ml, el);
        chk("mean_latency", ml, 33);
        chk("exp_latency", el, 34);
        chk("mean_50", longint'(bus.out_mean), 50);
        chk("exp_562", longint'(bus.out_exposure), 562);

        // 3: ramp to the upper clamp, then hold without a pulse
        foreach (ladder[i]) begin
            frame(32'd1000, 32'd50000, ml, el);
            chk("exp_ladder", longint'(bus.out_exposure), ladder[i]);
        end
        frame(32'd1000, 32'd50000, ml, el);
        chk("clamp_no_pulse", el, -1);
        chk("clamp_exposure", longint'(bus.out_exposure), 1000);
        chk("clamp_unlocked", longint'(bus.out_locked), 0);

        // 4: in band, then saturated mean
        frame(32'd1, 32'd130, ml, el);
        chk("band_locked", longint'(bus.out_locked), 1);
        chk("band_no_pulse", el, -1);
        chk("band_mean", longint'(bus.out_mean), 130);
        bus.skip_frames = 4'd2;
        frame(32'd1, 32'hFFFF_FFFF, ml, el);
        chk("sat_mean", longint'(bus.out_mean), 255);
        chk("sat_exposure", longint'(bus.out_exposure), 875);

        // 5: skip two frames, process the third; zero-count frame
        frame(32'd1000, 32'd50000, ml, el);
        chk("skip1_ignored", ml, -1);
        frame(32'd1000, 32'd50000, ml, el);
        chk("skip2_ignored", ml, -1);
        chk("skip_exposure", longint'(bus.out_exposure), 875);
        bus.skip_frames = 4'd0;
        frame(32'd1000, 32'd50000, ml, el);
        chk("skip3_processed", longint'(bus.out_exposure), 984);
        frame(32'd0, 32'd1234, ml, el);
        chk("cnt0_no_mean", ml, -1);
        chk("cnt0_exposure", longint'(bus.out_exposure), 984);

        // 6: enable drop in DIV, with a stat_done while busy
        @(negedge pclk);
        bus.stat_done = 1'b1; bus.stat_cnt = 32'd1000; bus.stat_sum = 32'd50000;
        @(posedge pclk); #1 bus.stat_done = 1'b0;
        idle(5);
        bus.stat_done = 1'b1;
        idle(1);
        bus.stat_done = 1'b0;
        idle(4);
        bus.enable = 1'b0;
        idle(1);
        chk("abort_idle", longint'(bus.out_busy), 0);
        chk("abort_exposure", longint'(bus.out_exposure), 984);
        chk("abort_unlocked", longint'(bus.out_locked), 0);
        bus.enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (bus.out_mean_valid === 1'b1 || bus.out_exp_valid === 1'b1) pulses++;
        end
        chk("abort_no_pulses", pulses, 0);

        // Ramp down to the lower clamp (step floor of 1)
        bus.target = 8'd128; bus.tolerance = 8'd8;
        for (int i = 0; i < 60; i++) frame(32'd1, 32'hFFFF_FFFF, ml, el);
        chk("min_exposure", longint'(bus.out_exposure), 1);
        frame(32'd1, 32'hFFFF_FFFF, ml, el);
        chk("min_no_pulse", el, -1);

        // Randomised frames
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            bus.target      = BITS'($urandom_range(0, 255));
            bus.tolerance   = (r == 0) ? BITS'($urandom_range(100, 255)) : BITS'($urandom_range(0, 30));
            bus.skip_frames = 4'($urandom_range(0, 3));
            rc = (r == 1) ? 32'd0 : 32'($urandom_range(1, 4000));
            if (r == 2 || rc == 0) rs = $urandom;
            else rs = rc * 32'($urandom_range(0, 300)) + 32'($urandom_range(0, int'(rc) - 1));
            if ($urandom_range(0, 7) == 0) abort_frame(rc, rs, $urandom_range(1, 36));
            else frame(rc, rs, ml, el);
            idle($urandom_range(0, 4));
        end
        idle(40);

        // Async reset mid-operation
        bus.target = 8'd200; bus.tolerance = 8'd4; bus.skip_frames = 4'd0;
        @(negedge pclk);
        bus.stat_done = 1'b1; bus.stat_cnt = 32'd10; bus.stat_sum = 32'd100;
        @(posedge pclk); #1 bus.stat_done = 1'b0;
        idle(5);
        rst_n = 1'b0;
        #1;
        chk("areset_exposure", longint'(bus.out_exposure), 500);
        chk("areset_busy", longint'(bus.out_busy), 0);
        chk("areset_mean", longint'(bus.out_mean), 0);
        @(negedge pclk) rst_n = 1'b1;
        frame(32'd10, 32'd100, ml, el);
        chk("post_reset_exposure", longint'(bus.out_exposure), 562);
        idle(5);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
